// File: rtl/acc_requant_pack.sv
// acc_requant_pack: bias, rounding shift, ReLU and int8 saturation, packed four lanes per 32-bit word
module acc_requant_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [31:0] cfg_bias,
    input  logic [4:0]  cfg_shift,
    input  logic        cfg_relu,
    input  logic        sat_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        sat_flag
);
    typedef enum logic {FILL, HOLD} state_e;
    state_e             state_q;
    logic [31:0]        pack_q, pack_d, out_data_q;
    logic [2:0]         out_bytes_q;
    logic [1:0]         idx_q;
    logic               sat_q;
    logic signed [33:0] t, rnd, r, rr;
    logic               clip_hi, clip_lo, accept, complete;
    logic [7:0]         q;
    assign out_valid = state_q == HOLD;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign sat_flag  = sat_q;
    assign in_ready  = ~out_valid | out_ready;
    // Requantise the incoming element; 34 bits hold bias + data + rounding term without wrap
    always_comb begin
        t        = {{2{in_data[31]}}, in_data} + {{2{cfg_bias[31]}}, cfg_bias};
        rnd      = cfg_shift == 5'd0 ? 34'sd0 : 34'sd1 <<< (cfg_shift - 5'd1);
        r        = (t + rnd) >>> cfg_shift;
        rr       = cfg_relu && r[33] ? 34'sd0 : r;
        clip_hi  = rr > 34'sd127;
        clip_lo  = rr < -34'sd128;
        q        = clip_hi ? 8'h7f : clip_lo ? 8'h80 : rr[7:0];
        accept   = in_valid & in_ready;
        complete = accept & (in_last | idx_q == 2'd3);
        pack_d   = pack_q | ({24'd0, q} << {idx_q, 3'b000});
    end
    // FILL/HOLD control, lane packing, word hand-off and sticky saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            pack_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            sat_q <= (accept & (clip_hi | clip_lo)) | (sat_q & ~sat_clr);
            if (complete) begin
                out_data_q  <= pack_d;
                out_bytes_q <= {1'b0, idx_q} + 3'd1;
                state_q     <= HOLD;
                idx_q       <= '0;
                pack_q      <= '0;
            end else begin
                if (accept) begin
                    pack_q <= pack_d;
                    idx_q  <= idx_q + 2'd1;
                end
                if (state_q == HOLD && out_ready) state_q <= FILL;
            end
        end
    end
endmodule
